mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning idle cycles between request acceptance and response (legal range 0..15).
REQ-002 The block SHALL have parameter RAM_WORDS, default 256, meaning 16-bit RAM words mapped at addresses 0x0000..RAM_WORDS-1.
REQ-003 The block SHALL have port Clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset_ah  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  CPU presents a memory request this cycle.
REQ-006 The block SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have port req_addr  input  16  request address (CPU MAR).
REQ-008 The block SHALL have port req_wdata  input  16  write data (CPU MDR).
REQ-009 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-010 The block SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-011 The block SHALL have port resp_rdata  output  16  read data (CPU Data_to_CPU), valid with resp_valid.
REQ-012 The block SHALL have port resp_err  output  1  unmapped address, valid with resp_valid.
REQ-013 The block SHALL have port SW  input  16  board switches, read-only MMIO at 0xFFFF.
REQ-014 The block SHALL have port HEX_reg  output  16  hex-display register, write-only MMIO at 0xFFFF.
REQ-015 The block SHALL have port overrun  output  1  sticky: a request arrived while req_ready was 0.

Function
REQ-016 The block SHALL implement states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on the edge where req_valid=1 and req_ready=1; req_we, req_addr and req_wdata SHALL be latched on that edge.
REQ-018 On acceptance the block SHALL go IDLE->WAIT with a down-counter loaded to WAIT_CYCLES, or IDLE->RESP directly when WAIT_CYCLES=0.
REQ-019 The WAIT counter SHALL decrement each cycle, and the block SHALL go WAIT->RESP on the edge where the counter reaches 0; total latency SHALL be WAIT_CYCLES+1 cycles from acceptance to resp_valid.
REQ-020 RESP SHALL last exactly one cycle, with resp_valid=1, and then return to IDLE, so back-to-back requests complete every WAIT_CYCLES+2 cycles.
REQ-021 Reads at addr < RAM_WORDS SHALL return RAM[addr]; reads at 0xFFFF SHALL return SW sampled on the edge entering RESP; all other reads SHALL return 0x0000 with resp_err=1.
REQ-022 Writes at addr < RAM_WORDS SHALL update RAM on the edge leaving RESP; writes at 0xFFFF SHALL update HEX_reg on the same edge; all other writes SHALL be discarded with resp_err=1.
REQ-023 A write response SHALL drive resp_rdata = latched write data.
REQ-024 A read following a write to the same address SHALL return the newly written value.
REQ-025 req_valid while not IDLE SHALL be ignored, SHALL not disturb the in-flight request, and SHALL set overrun.
REQ-026 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.

Reset
REQ-027 Reset_ah=1 SHALL immediately force state to IDLE, counter to 0, resp_valid=0, resp_rdata=0x0000, resp_err=0, HEX_reg=0x0000, overrun=0, and req_ready=1 while reset is held and after release.
REQ-028 Reset asserted mid-request SHALL abort that request; no RAM or HEX_reg write SHALL occur and no response SHALL be issued.
REQ-029 RAM contents SHALL not be cleared by reset.

Verification
REQ-030 With WAIT_CYCLES=2, write 0x1234 to 0x0010 at cycle 0, then read 0x0010 -> first resp_valid at cycle 3, second read resp at cycle 7 with rdata=0x1234 and err=0.
REQ-031 With SW=0xBEEF, read 0xFFFF -> rdata=0xBEEF; write 0x00A5 to 0xFFFF -> HEX_reg=0x00A5 after the response edge.
REQ-032 Read 0x8000 -> rdata=0x0000 and resp_err=1; write to 0x8000 -> RAM and HEX_reg unchanged and resp_err=1.
REQ-033 Hold req_valid=1 during WAIT -> overrun=1, and the in-flight response carries the original address data only.
REQ-034 Assert Reset_ah one cycle after accepting a write to 0xFFFF -> resp_valid never rises, HEX_reg=0x0000, and req_ready=1.
REQ-035 With WAIT_CYCLES=0, issue back-to-back reads -> resp_valid one cycle after each acceptance, and an accept every 2 cycles.

Source files
------------

// File: rtl/mem_io_responder.sv
// mem_io_responder: single-outstanding memory/MMIO responder with fixed wait latency,
// a 16-bit RAM at 0..RAM_WORDS-1 and switch/hex registers at 0xFFFF.
module mem_io_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_WORDS   = 256
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  input  logic [15:0] SW,
  output logic [15:0] HEX_reg,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [16:0] RAM_LIM   = 17'(RAM_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d, err_q, err_d, ovr_q, ovr_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, hex_q, hex_d;
  logic [15:0] ram [RAM_WORDS];
  logic        c_we, c_mmio, c_ram;
  logic [15:0] c_addr, c_wdata, c_rd;
  // In IDLE the live request is used so a zero-wait accept can respond next cycle.
  always_comb begin
    c_we    = (state_q == IDLE) ? req_we    : we_q;
    c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    c_mmio  = c_addr == 16'hFFFF;
    c_ram   = !c_mmio && ({1'b0, c_addr} < RAM_LIM);
    c_rd    = c_mmio ? SW : c_ram ? ram[c_addr[AW-1:0]] : 16'h0000;
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        cnt_d   = WAIT_INIT;
        we_d    = req_we;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
    // Response payload is captured on the edge entering RESP, zero otherwise.
    rdata_d = (state_d == RESP) ? (c_we ? c_wdata : c_rd) : 16'h0000;
    err_d   = (state_d == RESP) && !c_mmio && !c_ram;
    hex_d   = (state_q == RESP && c_we && c_mmio) ? c_wdata : hex_q;
    ovr_d   = ovr_q || (req_valid && state_q != IDLE);
  end
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      hex_q   <= 16'h0000;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      hex_q   <= hex_d;
      ovr_q   <= ovr_d;
    end
  end
  // RAM keeps its contents through reset; a reset drops state out of RESP so no write lands.
  always_ff @(posedge Clk) begin
    if (state_q == RESP && c_we && c_ram) ram[c_addr[AW-1:0]] <= c_wdata;
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign HEX_reg    = hex_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed checks of latency, RAM/MMIO decode, overrun and reset abort.
module tb_mem_io_responder;
  logic        clk = 1'b0, rst = 1'b0;
  logic        v, we, v0, we0;
  logic [15:0] a, wd, a0, wd0, sw;
  logic        rdy, rv, er, ovr, rdy0, rv0, er0, ovr0;
  logic [15:0] rd, hex, rd0, hex0;
  int          checks = 0, failures = 0;

  mem_io_responder #(.WAIT_CYCLES(2), .RAM_WORDS(256)) dut (
    .Clk(clk), .Reset_ah(rst), .req_valid(v), .req_we(we), .req_addr(a), .req_wdata(wd),
    .req_ready(rdy), .resp_valid(rv), .resp_rdata(rd), .resp_err(er),
    .SW(sw), .HEX_reg(hex), .overrun(ovr));

  mem_io_responder #(.WAIT_CYCLES(0), .RAM_WORDS(256)) dut0 (
    .Clk(clk), .Reset_ah(rst), .req_valid(v0), .req_we(we0), .req_addr(a0), .req_wdata(wd0),
    .req_ready(rdy0), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0),
    .SW(sw), .HEX_reg(hex0), .overrun(ovr0));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request through the WAIT_CYCLES=2 instance: response two edges after acceptance.
  task automatic req(input string tag, input logic w, input logic [15:0] ad, input logic [15:0] d,
                     input logic [15:0] exp_rd, input logic exp_er);
    v = 1'b1; we = w; a = ad; wd = d;
    cyc();
    v = 1'b0;
    chk({tag, "_busy"}, rdy, 0);
    chk({tag, "_w1"}, {rv, rd, er}, 0);
    cyc();
    chk({tag, "_w2"}, {rv, rd, er}, 0);
    cyc();
    chk({tag, "_valid"}, rv, 1);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, er, exp_er);
    cyc();
    chk({tag, "_done"}, {rdy, rv}, 2'b10);
  endtask

  initial begin
    v = 0; we = 0; a = 0; wd = 0; v0 = 0; we0 = 0; a0 = 0; wd0 = 0; sw = 16'hBEEF;
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {rdy, rv, rd, er, hex, ovr}, {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0});
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_release", {rdy, rv, ovr}, 3'b100);
    req("wr10", 1, 16'h0010, 16'h1234, 16'h1234, 0);
    req("rd10", 0, 16'h0010, 16'h0000, 16'h1234, 0);
    req("rdsw", 0, 16'hFFFF, 16'h0000, 16'hBEEF, 0);
    chk("hex_before", hex, 16'h0000);
    req("wrhex", 1, 16'hFFFF, 16'h00A5, 16'h00A5, 0);
    chk("hex_after", hex, 16'h00A5);
    req("wr00", 1, 16'h0000, 16'hCAFE, 16'hCAFE, 0);
    req("wrff", 1, 16'h00FF, 16'h0F0F, 16'h0F0F, 0);
    req("rdff", 0, 16'h00FF, 16'h0000, 16'h0F0F, 0);
    req("rd100", 0, 16'h0100, 16'h0000, 16'h0000, 1);
    req("rd8000", 0, 16'h8000, 16'h0000, 16'h0000, 1);
    req("wr8000", 1, 16'h8000, 16'h5555, 16'h5555, 1);
    chk("hex_keep", hex, 16'h00A5);
    req("rd00", 0, 16'h0000, 16'h0000, 16'hCAFE, 0);
    chk("ovr_clear", ovr, 0);
    // Keep req_valid high through WAIT with a different write; it must be ignored.
    v = 1; we = 0; a = 16'h0010; wd = 16'h0000;
    cyc();
    we = 1; a = 16'h00FF; wd = 16'hDEAD;
    cyc();
    chk("ovr_set", ovr, 1);
    cyc();
    chk("ovr_resp", {rv, rd, er}, {1'b1, 16'h1234, 1'b0});
    v = 0;
    cyc();
    req("ovr_nowr", 0, 16'h00FF, 16'h0000, 16'h0F0F, 0);
    chk("ovr_sticky", ovr, 1);
    // Reset one cycle after accepting an MMIO write aborts it.
    v = 1; we = 1; a = 16'hFFFF; wd = 16'h1111;
    cyc();
    v = 0;
    rst = 1'b1;
    #1;
    chk("abort_rst", {rdy, rv, hex, ovr}, {1'b1, 1'b0, 16'h0, 1'b0});
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("abort_norsp", {rdy, rv, hex}, {1'b1, 1'b0, 16'h0});
    end
    req("ram_kept", 0, 16'h0010, 16'h0000, 16'h1234, 0);
    // Zero-wait instance: held req_valid gives an accept every second cycle.
    v0 = 1; we0 = 1; a0 = 16'h0005; wd0 = 16'h0A0A;
    cyc();
    chk("z_wr", {rv0, rdy0, rd0, er0}, {1'b1, 1'b0, 16'h0A0A, 1'b0});
    we0 = 0;
    cyc();
    chk("z_idle1", {rv0, rdy0, rd0}, {1'b0, 1'b1, 16'h0});
    cyc();
    chk("z_rd1", {rv0, rd0, er0}, {1'b1, 16'h0A0A, 1'b0});
    a0 = 16'h9000;
    cyc();
    chk("z_idle2", {rv0, rdy0}, 2'b01);
    cyc();
    chk("z_rd2", {rv0, rd0, er0}, {1'b1, 16'h0000, 1'b1});
    v0 = 0;
    cyc();
    chk("z_end", {rv0, rdy0, ovr0}, 3'b011);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
